sevenseg_scan: RTL and testbench
================================

Name: sevenseg_scan

Overview:
- Display-side consumer of the 15-bit result tap that the single-cycle processor datapath exports for the Basys board.
- Captures the value on a load strobe and holds it.
- Time-multiplexes it as four hexadecimal digits on the board's common-anode 7-segment display, with optional leading-zero blanking and an anti-ghosting blank interval.
- Sits at the top level, between the processor core and the board pins.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range is 4 or more.
BLANK_CYC, 2000, cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-low reset.
value  input  15  result tap from the datapath; zero-extended to 16 bits, giving digit 3 as {1'b0, value[14:12]}.
load  input  1  when 1 at a rising edge, value is captured into the hold register.
blank_lz  input  1  enables leading-zero blanking.
seg  output  7  {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal point, active-low; held at 1 (off).
an  output  4  digit anodes, active-low one-hot; an[0] is the rightmost digit.
frame_done  output  1  one-cycle pulse when the digit index wraps from 3 to 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - hold=0, prescaler=0, digit index=0.
  - seg=7'h7F, an=4'hF, dp=1, frame_done=0.
- Hold register: loads {1'b0,value} on each edge with load=1; otherwise keeps its value.
- Prescaler counts 0..REFRESH_DIV-1 and wraps to 0. At the terminal count the digit index advances 0,1,2,3,0.
- frame_done: registered; it is 1 in the cycle after the edge at which the index goes from 3 to 0.
- Slot timing:
  - Prescaler < BLANK_CYC: the next-state an is 4'hF and seg is 7'h7F.
  - Otherwise: an has bit[index]=0 and all other bits 1; seg is the decode of the nibble hold[4*index+3 : 4*index].
- Output latency: seg, an and frame_done are registered. Pins reflect the prescaler, index and hold state one cycle late.
- Hex decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - all values in hex.
- Leading-zero blanking: when blank_lz=1, digit i (i=1..3) is blanked if hold[15:4i]==0. The anode stays on, but seg=7'h7F. Digit 0 is never blanked.
- Simultaneous load and slot change: the new hold value is used from the first output update after the load edge, regardless of which digit is then active.
- value changes without load have no visible effect.
- reset asserted mid-scan: outputs return to their reset values immediately (asynchronous).
- Release of reset: the scan restarts at digit 0 with a full blank interval.

Test Plan:
1. REFRESH_DIV=4, BLANK_CYC=1; reset released; load 15'h1234.
   - Each slot is 1 cycle of an=F, then 3 cycles of the digit.
   - Digit 0: an=E, seg=19 ("4").
   - Digit 1: an=D, seg=30 ("3").
   - Digit 2: an=B, seg=24 ("2").
   - Digit 3: an=7, seg=79 ("1").
   - frame_done pulses once per 16 cycles.
2. Load 15'h7FFF.
   - Digit 3 shows seg=78 ("7").
   - Digits 0-2 show seg=0E ("F").
3. blank_lz=1, load 15'h0005.
   - Digits 3..1: an is active but seg=7F.
   - Digit 0: seg=12 ("5").
   - Repeat with load 15'h0000: digit 0 shows 40 ("0"), all others are blank.
4. Pulse load with 15'h0ABC at the same edge as a slot terminal count.
   - The next non-blank digit shows the new nibble.
   - value changed later without load produces no change.
5. Assert reset mid-slot (digit 2 active).
   - an=F, seg=7F and frame_done=0 immediately, before the next clock edge.
   - After release: blank cycle, then digit 0, with hold=0 showing seg=40.
6. Hold load=0 for 3 frames after loading 15'h4321.
   - frame_done pulses exactly 3 times, 16 cycles apart.
   - The digit pattern is identical every frame.

Source files
------------

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: hold a 15-bit result tap and time-multiplex it as four hex digits on a common-anode display
module sevenseg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam int PW = $clog2(REFRESH_DIV);
  logic [15:0]   hold;
  logic [PW-1:0] pre;
  logic [1:0]    idx;
  logic          wrap;
  logic          blank;
  logic          lz;
  logic [15:0]   upper;
  function automatic logic [6:0] hex(input logic [3:0] n);
    case (n)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      default: hex = 7'h0E;
    endcase
  endfunction
  always_comb begin
    wrap = pre == PW'(REFRESH_DIV - 1);
    blank = pre < PW'(BLANK_CYC);
    upper = hold >> {idx, 2'b00};
    // a digit above the most significant non-zero nibble is dark but keeps its slot
    lz = blank_lz && idx != 2'd0 && upper == 16'd0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold <= '0;
      pre <= '0;
      idx <= '0;
    end else begin
      if (load) hold <= {1'b0, value};
      pre <= wrap ? '0 : pre + 1'b1;
      if (wrap) idx <= idx + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg <= 7'h7F;
      an <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      seg <= blank || lz ? 7'h7F : hex(upper[3:0]);
      an <= blank ? 4'hF : ~(4'b0001 << idx);
      frame_done <= wrap && idx == 2'd3;
    end
  end
  assign dp = 1'b1;
endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan: randomized and directed scan checks against a cycle-count reference model
module tb_sevenseg_scan;
  localparam int DIV = 4;
  localparam int BLANK = 1;
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic clk = 0, reset = 0, load = 0, blank_lz = 0;
  logic [14:0] value = '0;
  logic [6:0] seg;
  logic dp, frame_done;
  logic [3:0] an;
  int tests = 0, fails = 0, k = 0, mhold = 0;
  logic [11:0] exp_p;

  sevenseg_scan #(.REFRESH_DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // expected {seg,an,frame_done} after the edge taken with k edges elapsed since reset release
  function automatic logic [11:0] model(int kk, int h, logic blz);
    int p = kk % DIV;
    int d = (kk / DIV) % 4;
    logic [6:0] s;
    logic [3:0] a;
    if (p < BLANK) begin
      s = 7'h7F;
      a = 4'hF;
    end else begin
      a = 4'hF ^ (4'd1 << d);
      s = (blz && d > 0 && h < (1 << (4 * d))) ? 7'h7F : HEX[(h >> (4 * d)) & 15];
    end
    return {s, a, (kk % (4 * DIV)) == 4 * DIV - 1};
  endfunction

  task automatic tick();
    @(posedge clk);
    exp_p = model(k, mhold, blank_lz);
    if (load) mhold = int'(value);
    k++;
    #1;
  endtask

  task automatic test_reset();
    #7;
    tests++;
    if ({seg, an, frame_done, dp} !== {7'h7F, 4'hF, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL reset_state got seg=%h an=%h fd=%b dp=%b exp seg=7f an=f fd=0 dp=1", seg, an, frame_done, dp);
    end
    #4 reset = 1;
    k = 0;
    mhold = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if ({seg, an, frame_done, dp} !== {exp_p, 1'b1}) begin
        fails++;
        $display("FAIL reset_scan k=%0d got seg=%h an=%h fd=%b exp seg=%h an=%h fd=%b", k, seg, an, frame_done, exp_p[11:5], exp_p[4:1], exp_p[0]);
      end
    end
  endtask

  task automatic test_load_value(input logic [14:0] v, input logic blz, input int n, input string name);
    blank_lz = blz;
    value = v;
    load = 1;
    tick();
    load = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      tests++;
      if ({seg, an, frame_done, dp} !== {exp_p, 1'b1}) begin
        fails++;
        $display("FAIL %s k=%0d got seg=%h an=%h fd=%b exp seg=%h an=%h fd=%b", name, k, seg, an, frame_done, exp_p[11:5], exp_p[4:1], exp_p[0]);
      end
    end
  endtask

  task automatic test_load_at_tc();
    blank_lz = 0;
    while (k % DIV != DIV - 1) tick();
    value = 15'h0ABC;
    load = 1;
    tick();
    load = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5) value = 15'h5555;
      tick();
      tests++;
      if ({seg, an, frame_done, dp} !== {exp_p, 1'b1}) begin
        fails++;
        $display("FAIL load_at_tc k=%0d got seg=%h an=%h fd=%b exp seg=%h an=%h fd=%b", k, seg, an, frame_done, exp_p[11:5], exp_p[4:1], exp_p[0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    while (k % (4 * DIV) != 2 * DIV + 2) tick();
    tests++;
    if (an !== 4'hB) begin
      fails++;
      $display("FAIL mid_reset_pre got an=%h exp an=b", an);
    end
    #2 reset = 0;
    #1;
    tests++;
    if ({seg, an, frame_done} !== {7'h7F, 4'hF, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset_async got seg=%h an=%h fd=%b exp seg=7f an=f fd=0", seg, an, frame_done);
    end
    #3 reset = 1;
    k = 0;
    mhold = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if ({seg, an, frame_done, dp} !== {exp_p, 1'b1}) begin
        fails++;
        $display("FAIL mid_reset_after k=%0d got seg=%h an=%h fd=%b exp seg=%h an=%h fd=%b", k, seg, an, frame_done, exp_p[11:5], exp_p[4:1], exp_p[0]);
      end
    end
  endtask

  task automatic test_frames();
    logic [11:0] pat [48];
    int pulses = 0, last = -1;
    blank_lz = 0;
    value = 15'h4321;
    load = 1;
    tick();
    load = 0;
    while (k % (4 * DIV) != 0) tick();
    for (int i = 0; i < 48; i++) begin
      tick();
      pat[i] = {seg, an, frame_done};
      if (frame_done === 1'b1) begin
        if (last >= 0) begin
          tests++;
          if (i - last != 4 * DIV) begin
            fails++;
            $display("FAIL frame_spacing got %0d exp %0d", i - last, 4 * DIV);
          end
        end
        pulses++;
        last = i;
      end
      tests++;
      if ({seg, an, frame_done, dp} !== {exp_p, 1'b1}) begin
        fails++;
        $display("FAIL frames k=%0d got seg=%h an=%h fd=%b exp seg=%h an=%h fd=%b", k, seg, an, frame_done, exp_p[11:5], exp_p[4:1], exp_p[0]);
      end
    end
    tests++;
    if (pulses != 3) begin
      fails++;
      $display("FAIL frame_count got %0d exp 3", pulses);
    end
    for (int i = 0; i < 32; i++) begin
      tests++;
      if (pat[i + 16] !== pat[i]) begin
        fails++;
        $display("FAIL frame_repeat slot=%0d got %h exp %h", i, pat[i + 16], pat[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load = $urandom_range(0, 7) == 0;
      value = 15'($urandom >> $urandom_range(3, 31));
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      tick();
      tests++;
      if ({seg, an, frame_done, dp} !== {exp_p, 1'b1}) begin
        fails++;
        $display("FAIL random k=%0d got seg=%h an=%h fd=%b exp seg=%h an=%h fd=%b", k, seg, an, frame_done, exp_p[11:5], exp_p[4:1], exp_p[0]);
      end
    end
    load = 0;
  endtask

  initial begin
    test_reset();
    test_load_value(15'h1234, 1'b0, 40, "digits_1234");
    test_load_value(15'h7FFF, 1'b0, 40, "digits_7fff");
    test_load_value(15'h0005, 1'b1, 40, "lz_0005");
    test_load_value(15'h0000, 1'b1, 40, "lz_0000");
    test_load_value(15'h0120, 1'b1, 40, "lz_0120");
    test_load_at_tc();
    test_mid_reset();
    test_frames();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
